// File: rtl/arb_pkg.sv
// Shared definitions for the hierarchical bank arbiter: FSM state encoding,
// default parameter values and an index-width helper used by all arbiter files.
// No ports; imported by rr_picker and hier_bank_arbiter.
package arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int DEF_NUM_GROUPS      = 4;
    localparam int DEF_BANKS_PER_GROUP = 4;
    localparam int DEF_REQ_SIZE        = 32;
    localparam int DEF_MAX_BURST       = 4;

    // Index width that never collapses to zero bits for a one-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: finds the first set bit of mask at or after pointer, wrapping.
// Ports: mask/pointer in; found (any bit set) and index (winning position) out.
// Purely combinational, zero latency, no backpressure.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    input  logic [PW-1:0]    pointer,
    output logic             found,
    output logic [PW-1:0]    index
);

    int pos;

    // Walk from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            pos = (int'(pointer) + i) % WIDTH;
            if (mask[PW'(pos)]) begin
                found = 1'b1;
                index = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/hier_bank_arbiter.sv
// Two-level round-robin arbiter: picks a bank group, then a bank within it, and
// streams up to MAX_BURST words from that bank; one ARB bubble between grants.
// Ports: clk/rst (sync, active-high); req/valid/data_in per bank; out_ready in;
// out_valid/data_out/ack/grant_idx out. Optional ARB_PRIORITY_EN adds prio[N-1:0].
// Latency: eligible in ARB at t -> out_valid at t+1. Backpressure: out_ready=0
// holds the grant and data_out selection with no ack.
module hier_bank_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_GROUPS      = DEF_NUM_GROUPS,
    parameter  int BANKS_PER_GROUP = DEF_BANKS_PER_GROUP,
    parameter  int REQ_SIZE        = DEF_REQ_SIZE,
    parameter  int MAX_BURST       = DEF_MAX_BURST,
    localparam int N               = NUM_GROUPS * BANKS_PER_GROUP,
    localparam int IW              = idx_w(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          valid,
    input  logic [N*REQ_SIZE-1:0] data_in,
`ifdef ARB_PRIORITY_EN
    input  logic [N-1:0]          prio,
`endif
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [REQ_SIZE-1:0]   data_out,
    output logic [N-1:0]          ack,
    output logic [IW-1:0]         grant_idx
);

    localparam int GW = idx_w(NUM_GROUPS);
    localparam int BW = idx_w(BANKS_PER_GROUP);
    localparam int CW = idx_w(MAX_BURST);

    state_t          state;
    logic [GW-1:0]   grp_ptr;
    logic [BW-1:0]   bank_ptr [NUM_GROUPS];
    logic [CW-1:0]   burst_cnt;

    logic [N-1:0]               eligible;
    logic [N-1:0]               compete;
    logic [NUM_GROUPS-1:0]      grp_any;
    logic [BANKS_PER_GROUP-1:0] bank_mask;
    logic [BW-1:0]              cur_bank_ptr;
    logic                       grp_found;
    logic                       bank_found;
    logic [GW-1:0]              grp_sel;
    logic [BW-1:0]              bank_sel;
    logic [IW-1:0]              pick_idx;

    logic                grant_elig;
    logic [REQ_SIZE-1:0] sel_dat;
    logic                serving;
    logic                xfer;
    logic                last_xfer;
    logic [GW-1:0]       srv_grp;
    logic [BW-1:0]       srv_bank;

    assign eligible = req & valid;

`ifdef ARB_PRIORITY_EN
    // Prioritised banks shadow the rest only while at least one is eligible.
    logic [N-1:0] prio_hit;
    assign prio_hit = prio & eligible;
    assign compete  = (|prio_hit) ? prio_hit : eligible;
`else
    assign compete = eligible;
`endif

    always_comb begin
        grp_any = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_any[g] = |compete[g*BANKS_PER_GROUP +: BANKS_PER_GROUP];
        end
    end

    rr_picker #(.WIDTH(NUM_GROUPS)) u_grp_pick (
        .mask    (grp_any),
        .pointer (grp_ptr),
        .found   (grp_found),
        .index   (grp_sel)
    );

    // Constant-base mux keeps the group slice lint-clean for any parameter set.
    always_comb begin
        bank_mask    = '0;
        cur_bank_ptr = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (GW'(g) == grp_sel) begin
                bank_mask    = compete[g*BANKS_PER_GROUP +: BANKS_PER_GROUP];
                cur_bank_ptr = bank_ptr[g];
            end
        end
    end

    rr_picker #(.WIDTH(BANKS_PER_GROUP)) u_bank_pick (
        .mask    (bank_mask),
        .pointer (cur_bank_ptr),
        .found   (bank_found),
        .index   (bank_sel)
    );

    assign pick_idx = IW'(int'(grp_sel) * BANKS_PER_GROUP + int'(bank_sel));

    always_comb begin
        grant_elig = 1'b0;
        sel_dat    = '0;
        for (int b = 0; b < N; b++) begin
            if (IW'(b) == grant_idx) begin
                grant_elig = eligible[b];
                sel_dat    = data_in[b*REQ_SIZE +: REQ_SIZE];
            end
        end
    end

    // Reset gates the outputs so an in-flight grant is aborted without an ack.
    assign serving   = (state == SERVE) && !rst;
    assign out_valid = serving && grant_elig;
    assign xfer      = out_valid && out_ready;
    assign ack       = xfer ? (N'(1) << grant_idx) : '0;
    assign data_out  = serving ? sel_dat : '0;
    assign last_xfer = xfer && (burst_cnt == CW'(MAX_BURST - 1));

    assign srv_grp  = GW'(int'(grant_idx) / BANKS_PER_GROUP);
    assign srv_bank = BW'(int'(grant_idx) % BANKS_PER_GROUP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            grp_ptr   <= '0;
            burst_cnt <= '0;
            grant_idx <= '0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                bank_ptr[g] <= '0;
            end
        end else begin
            case (state)
                ARB: begin
                    if (grp_found && bank_found) begin
                        grant_idx <= pick_idx;
                        burst_cnt <= '0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    // Advance both pointers past the served bank/group on exit.
                    if (!grant_elig || last_xfer) begin
                        state             <= ARB;
                        bank_ptr[srv_grp] <= BW'((int'(srv_bank) + 1) % BANKS_PER_GROUP);
                        grp_ptr           <= GW'((int'(srv_grp) + 1) % NUM_GROUPS);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_bank_arbiter.sv
module tb_hier_bank_arbiter;

    logic          clk;
    logic          rst;
    logic [15:0]   req;
    logic [15:0]   valid;
    logic [511:0]  data_in;
    logic          out_ready;
`ifdef ARB_PRIORITY_EN
    logic [15:0]   prio;
`endif

    logic          out_valid;
    logic [31:0]   data_out;
    logic [15:0]   ack;
    logic [3:0]    grant_idx;

    logic          out_valid1;
    logic [31:0]   data_out1;
    logic [15:0]   ack1;
    logic [3:0]    grant_idx1;

    int n_cmp;
    int n_err;

    hier_bank_arbiter #(
        .NUM_GROUPS(4), .BANKS_PER_GROUP(4), .REQ_SIZE(32), .MAX_BURST(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .valid     (valid),
        .data_in   (data_in),
`ifdef ARB_PRIORITY_EN
        .prio      (prio),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .ack       (ack),
        .grant_idx (grant_idx)
    );

    hier_bank_arbiter #(
        .NUM_GROUPS(4), .BANKS_PER_GROUP(4), .REQ_SIZE(32), .MAX_BURST(1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .valid     (valid),
        .data_in   (data_in),
`ifdef ARB_PRIORITY_EN
        .prio      (prio),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid1),
        .data_out  (data_out1),
        .ack       (ack1),
        .grant_idx (grant_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        valid     = '0;
        out_ready = 1'b0;
`ifdef ARB_PRIORITY_EN
        prio      = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (ack !== 16'h0) begin
            n_err++; $display("FAIL reset_ack: got %h want 0000", ack);
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_err++; $display("FAIL reset_data_out: got %h want 0", data_out);
        end
        n_cmp++;
        if (grant_idx !== 4'd0) begin
            n_err++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx);
        end
    endtask

    // Lone bank 5: four-word burst, one bubble, then regranted.
    task automatic test_single_burst();
        do_reset();
        req       = 16'h0020;
        valid     = 16'h0020;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL burst_arb_idle: out_valid got %b want 0", out_valid);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (grant_idx !== 4'd5) begin
                n_err++; $display("FAIL burst_grant[%0d]: got %0d want 5", k, grant_idx);
            end
            n_cmp++;
            if (ack !== 16'h0020) begin
                n_err++; $display("FAIL burst_ack[%0d]: got %h want 0020", k, ack);
            end
            n_cmp++;
            if (data_out !== 32'hA000_0005) begin
                n_err++; $display("FAIL burst_data[%0d]: got %h want a0000005", k, data_out);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || ack !== 16'h0) begin
            n_err++; $display("FAIL burst_bubble: out_valid %b ack %h want 0/0000", out_valid, ack);
        end
        tick();
        n_cmp++;
        if (grant_idx !== 4'd5 || ack !== 16'h0020) begin
            n_err++; $display("FAIL burst_regrant: grant %0d ack %h want 5/0020", grant_idx, ack);
        end
    endtask

    // Single-word grants across groups 0 and 1 exercise both pointer levels.
    task automatic test_round_robin();
        logic [3:0] exp_order [5];
        exp_order[0] = 4'd0;
        exp_order[1] = 4'd4;
        exp_order[2] = 4'd1;
        exp_order[3] = 4'd4;
        exp_order[4] = 4'd0;
        do_reset();
        req       = 16'h0013;
        valid     = 16'h0013;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (out_valid1 !== 1'b0) begin
                n_err++; $display("FAIL rr_bubble[%0d]: out_valid got %b want 0", k, out_valid1);
            end
            tick();
            n_cmp++;
            if (grant_idx1 !== exp_order[k]) begin
                n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_idx1, exp_order[k]);
            end
            n_cmp++;
            if (ack1 !== (16'h1 << exp_order[k])) begin
                n_err++; $display("FAIL rr_ack[%0d]: got %h want %h", k, ack1, 16'h1 << exp_order[k]);
            end
            tick();
        end
    endtask

    // Bank 2 held off by out_ready for three cycles, then accepted.
    task automatic test_stall();
        do_reset();
        req       = 16'h0004;
        valid     = 16'h0004;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid);
            end
            n_cmp++;
            if (data_out !== 32'hA000_0002 || grant_idx !== 4'd2) begin
                n_err++; $display("FAIL stall_hold[%0d]: data %h grant %0d want a0000002/2", k, data_out, grant_idx);
            end
            n_cmp++;
            if (ack !== 16'h0) begin
                n_err++; $display("FAIL stall_ack[%0d]: got %h want 0000", k, ack);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (ack !== 16'h0004) begin
            n_err++; $display("FAIL stall_release_ack: got %h want 0004", ack);
        end
    endtask

    // Bank 3 drops valid after two words; group-0 pointer must wrap to bank 0.
    task automatic test_valid_drop();
        do_reset();
        req       = 16'h0008;
        valid     = 16'h0008;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack !== 16'h0008) begin
                n_err++; $display("FAIL drop_ack[%0d]: got %h want 0008", k, ack);
            end
            tick();
        end
        valid = 16'h0000;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || ack !== 16'h0) begin
            n_err++; $display("FAIL drop_no_third: out_valid %b ack %h want 0/0000", out_valid, ack);
        end
        tick();
        req   = 16'h0009;
        valid = 16'h0009;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL drop_back_in_arb: out_valid got %b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (grant_idx !== 4'd0) begin
            n_err++; $display("FAIL drop_bank_ptr_wrap: grant got %0d want 0", grant_idx);
        end
    endtask

    // Reset mid-burst aborts without ack and returns to ARB.
    task automatic test_reset_mid_burst();
        do_reset();
        req       = 16'h0020;
        valid     = 16'h0020;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ack !== 16'h0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_abort: ack %h out_valid %b want 0000/0", ack, out_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || ack !== 16'h0 || data_out !== 32'h0 || grant_idx !== 4'd0) begin
            n_err++; $display("FAIL rst_after: valid %b ack %h data %h grant %0d want all 0",
                              out_valid, ack, data_out, grant_idx);
        end
        tick();
        n_cmp++;
        if (grant_idx !== 4'd5 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_regrant: grant %0d valid %b want 5/1", grant_idx, out_valid);
        end
    endtask

`ifdef ARB_PRIORITY_EN
    task automatic test_priority();
        do_reset();
        req       = 16'h0201;
        valid     = 16'h0201;
        prio      = 16'h0200;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (grant_idx !== 4'd9) begin
            n_err++; $display("FAIL prio_grant: got %0d want 9", grant_idx);
        end
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req       = '0;
        valid     = '0;
        out_ready = 1'b0;
`ifdef ARB_PRIORITY_EN
        prio      = '0;
`endif
        for (int b = 0; b < 16; b++) begin
            data_in[b*32 +: 32] = 32'hA000_0000 + b;
        end
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_valid_drop();
        test_reset_mid_burst();
`ifdef ARB_PRIORITY_EN
        test_priority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
